// File: rtl/pio_fifo_pair.sv
// TX/RX FIFO pair for one PIO state machine.
// Both directions share one 2*DEPTH-entry storage array. Unjoined, TX owns the
// lower half and RX the upper half; when joined, the enabled direction owns the
// whole array and the other direction has zero capacity (reads empty and full).
// Reads are first-word-fall-through: dout is always the entry at the head pointer.
module pio_fifo_pair #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 4,
   localparam int LW    = $clog2(2*DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   // Join selector; "join" itself is a reserved word, hence join_mode.
   input  logic [1:0]       join_mode,
   input  logic             flush,
   input  logic             clr_flags,
   input  logic             tx_push,
   input  logic [WIDTH-1:0] tx_din,
   input  logic             tx_pull,
   output logic [WIDTH-1:0] tx_dout,
   output logic             tx_empty,
   output logic             tx_full,
   output logic [LW-1:0]    tx_level,
   input  logic             rx_push,
   input  logic [WIDTH-1:0] rx_din,
   input  logic             rx_pull,
   output logic [WIDTH-1:0] rx_dout,
   output logic             rx_empty,
   output logic             rx_full,
   output logic [LW-1:0]    rx_level,
   output logic             tx_over,
   output logic             rx_under
);

   localparam int AW = $clog2(2*DEPTH);

   // Encoding 2'b11 behaves exactly like JOIN_NONE but is kept distinct so a
   // change between 00 and 11 is still seen as a join change.
   typedef enum logic [1:0] {
      JOIN_NONE = 2'b00,
      JOIN_TX   = 2'b01,
      JOIN_RX   = 2'b10,
      JOIN_ALT  = 2'b11
   } join_e;

   // Pointers are relative to the direction's base entry and wrap at its capacity.
   typedef struct packed {
      logic [AW-1:0] head;
      logic [AW-1:0] tail;
      logic [LW-1:0] level;
   } fifo_t;

   join_e            join_q;
   fifo_t            tx_q, rx_q, tx_d, rx_d;
   logic [WIDTH-1:0] mem [2*DEPTH];

   logic [LW-1:0]    tx_cap, rx_cap;
   logic [AW-1:0]    rx_base;
   logic [AW-1:0]    tx_waddr, tx_raddr, rx_waddr, rx_raddr;
   logic             clear;
   logic             tx_push_ok, tx_pull_ok, rx_push_ok, rx_pull_ok;

   // Advance a relative pointer, wrapping at the current capacity.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr,
                                             input logic [LW-1:0] cap);
      if ({1'b0, ptr} == cap - LW'(1))
         return '0;
      else
         return ptr + AW'(1);
   endfunction

   // Next pointer/level state for one direction.
   function automatic fifo_t fifo_next(input fifo_t         cur,
                                       input logic [LW-1:0] cap,
                                       input logic          clr,
                                       input logic          push_ok,
                                       input logic          pull_ok);
      fifo_t nxt;
      nxt = cur;
      if (clr) begin
         nxt = '0;
      end else begin
         if (push_ok) nxt.tail = ptr_inc(cur.tail, cap);
         if (pull_ok) nxt.head = ptr_inc(cur.head, cap);
         if (push_ok && !pull_ok)
            nxt.level = cur.level + LW'(1);
         else if (pull_ok && !push_ok)
            nxt.level = cur.level - LW'(1);
      end
      return nxt;
   endfunction

   // Capacity and storage base of each direction for the registered join mode.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path through the case can leave it unassigned and infer a latch.
      tx_cap  = LW'(DEPTH);
      rx_cap  = LW'(DEPTH);
      rx_base = AW'(DEPTH);
      case (join_q)
         JOIN_TX: begin
            tx_cap = LW'(2*DEPTH);
            rx_cap = '0;
         end
         JOIN_RX: begin
            tx_cap  = '0;
            rx_cap  = LW'(2*DEPTH);
            rx_base = '0;
         end
         default: ;
      endcase
   end

   // Status decode from registered state only; nothing here sees push/pull.
   assign tx_level = tx_q.level;
   assign rx_level = rx_q.level;
   assign tx_empty = (tx_q.level == '0);
   assign rx_empty = (rx_q.level == '0);
   assign tx_full  = (tx_q.level == tx_cap);
   assign rx_full  = (rx_q.level == rx_cap);

   // A join change flushes like an explicit flush and discards all traffic.
   assign clear = flush || (join_mode != join_q);

   assign tx_push_ok = tx_push && !tx_full  && !clear;
   assign tx_pull_ok = tx_pull && !tx_empty && !clear;
   assign rx_push_ok = rx_push && !rx_full  && !clear;
   assign rx_pull_ok = rx_pull && !rx_empty && !clear;

   // Absolute array addresses: TX always starts at entry 0.
   assign tx_waddr = tx_q.tail;
   assign tx_raddr = tx_q.head;
   assign rx_waddr = rx_base + rx_q.tail;
   assign rx_raddr = rx_base + rx_q.head;

   assign tx_dout = mem[tx_raddr];
   assign rx_dout = mem[rx_raddr];

   // Next-state for both directions.
   always_comb begin
      tx_d = fifo_next(tx_q, tx_cap, clear, tx_push_ok, tx_pull_ok);
      rx_d = fifo_next(rx_q, rx_cap, clear, rx_push_ok, rx_pull_ok);
   end

   // Pointer, level and join-mode registers.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!reset_n) begin
         tx_q   <= '0;
         rx_q   <= '0;
         join_q <= JOIN_NONE;
      end else begin
         tx_q   <= tx_d;
         rx_q   <= rx_d;
         join_q <= join_e'(join_mode);
      end
   end

   // Storage writes; the two directions never target the same entry.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; the levels alone define which entries are
      // valid, so clearing the contents would buy nothing.
      if (tx_push_ok) mem[tx_waddr] <= tx_din;
      if (rx_push_ok) mem[rx_waddr] <= rx_din;
   end

   // Sticky error flags; a set in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_over  <= 1'b0;
         rx_under <= 1'b0;
      end else begin
         if (tx_push && tx_full)
            tx_over <= 1'b1;
         else if (clr_flags)
            tx_over <= 1'b0;

         if (rx_pull && rx_empty)
            rx_under <= 1'b1;
         else if (clr_flags)
            rx_under <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pio_fifo_pair.sv
// Self-checking bench for pio_fifo_pair: a table of per-cycle vectors with
// hand-derived levels/flags, a queue-based scoreboard for data and status, and
// hand-written reset sequences.
module tb_pio_fifo_pair;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(2*DEPTH) + 1;

   logic             clk;
   logic             reset_n;
   logic [1:0]       join_mode;
   logic             flush, clr_flags;
   logic             tx_push, tx_pull, rx_push, rx_pull;
   logic [WIDTH-1:0] tx_din, rx_din, tx_dout, rx_dout;
   logic             tx_empty, tx_full, rx_empty, rx_full;
   logic [LW-1:0]    tx_level, rx_level;
   logic             tx_over, rx_under;

   pio_fifo_pair #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .join_mode(join_mode), .flush(flush),
      .clr_flags(clr_flags), .tx_push(tx_push), .tx_din(tx_din),
      .tx_pull(tx_pull), .tx_dout(tx_dout), .tx_empty(tx_empty),
      .tx_full(tx_full), .tx_level(tx_level), .rx_push(rx_push),
      .rx_din(rx_din), .rx_pull(rx_pull), .rx_dout(rx_dout),
      .rx_empty(rx_empty), .rx_full(rx_full), .rx_level(rx_level),
      .tx_over(tx_over), .rx_under(rx_under)
   );

   typedef struct {
      logic [1:0]  jn;
      bit          fl, clr, tp, tpl, rp, rpl;
      logic [31:0] td, rd;
      int          txl, rxl, ov, un;
   } vec_t;

   vec_t        vecs[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   // Reference model state: word queues per direction plus mode and flags.
   logic [31:0] txm[$];
   logic [31:0] rxm[$];
   logic [1:0]  join_m;
   bit          over_m, under_m;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t v(input int jn, fl, clr, tp, td, tpl, rp, rd, rpl,
                              txl, rxl, ov, un);
      vec_t r;
      r.jn  = 2'(jn);
      r.fl  = (fl != 0);  r.clr = (clr != 0);
      r.tp  = (tp != 0);  r.tpl = (tpl != 0);
      r.rp  = (rp != 0);  r.rpl = (rpl != 0);
      r.td  = 32'(td);    r.rd  = 32'(rd);
      r.txl = txl; r.rxl = rxl; r.ov = ov; r.un = un;
      return r;
   endfunction

   function automatic int cap_tx(input logic [1:0] j);
      return (j == 2'b01) ? 2*DEPTH : (j == 2'b10) ? 0 : DEPTH;
   endfunction

   function automatic int cap_rx(input logic [1:0] j);
      return (j == 2'b10) ? 2*DEPTH : (j == 2'b01) ? 0 : DEPTH;
   endfunction

   task automatic drive_idle();
      join_mode = join_m; flush = 0; clr_flags = 0;
      tx_push = 0; tx_pull = 0; rx_push = 0; rx_pull = 0;
      tx_din = '0; rx_din = '0;
   endtask

   task automatic model_reset();
      txm.delete(); rxm.delete();
      join_m = 2'b00; over_m = 0; under_m = 0;
   endtask

   // Advance the model by one clock edge using the vector just applied.
   task automatic model_step(input vec_t x);
      bit t_full, t_empty, r_full, r_empty;
      t_full  = (txm.size() == cap_tx(join_m));
      t_empty = (txm.size() == 0);
      r_full  = (rxm.size() == cap_rx(join_m));
      r_empty = (rxm.size() == 0);
      if (x.tp && t_full) over_m = 1; else if (x.clr) over_m = 0;
      if (x.rpl && r_empty) under_m = 1; else if (x.clr) under_m = 0;
      if (x.fl || x.jn != join_m) begin
         txm.delete(); rxm.delete();
         join_m = x.jn;
      end else begin
         if (x.tpl && !t_empty) void'(txm.pop_front());
         if (x.tp && !t_full) txm.push_back(x.td);
         if (x.rpl && !r_empty) void'(rxm.pop_front());
         if (x.rp && !r_full) rxm.push_back(x.rd);
      end
   endtask

   task automatic model_check(input string tag);
      check({tag, " tx_level"}, 32'(tx_level), 32'(txm.size()));
      check({tag, " rx_level"}, 32'(rx_level), 32'(rxm.size()));
      check({tag, " tx_empty"}, 32'(tx_empty), (txm.size() == 0) ? 1 : 0);
      check({tag, " rx_empty"}, 32'(rx_empty), (rxm.size() == 0) ? 1 : 0);
      check({tag, " tx_full"}, 32'(tx_full), (txm.size() == cap_tx(join_m)) ? 1 : 0);
      check({tag, " rx_full"}, 32'(rx_full), (rxm.size() == cap_rx(join_m)) ? 1 : 0);
      check({tag, " tx_over"}, 32'(tx_over), 32'(over_m));
      check({tag, " rx_under"}, 32'(rx_under), 32'(under_m));
      if (txm.size() > 0) check({tag, " tx_dout"}, tx_dout, txm[0]);
      if (rxm.size() > 0) check({tag, " rx_dout"}, rx_dout, rxm[0]);
   endtask

   // Drive one vector at the falling edge, clock it, and compare at the next fall.
   task automatic apply(input vec_t x, input string tag);
      join_mode = x.jn; flush = x.fl; clr_flags = x.clr;
      tx_push = x.tp; tx_din = x.td; tx_pull = x.tpl;
      rx_push = x.rp; rx_din = x.rd; rx_pull = x.rpl;
      @(posedge clk);
      model_step(x);
      @(negedge clk);
      model_check(tag);
      check({tag, " tx_level(table)"}, 32'(tx_level), 32'(x.txl));
      check({tag, " rx_level(table)"}, 32'(rx_level), 32'(x.rxl));
      check({tag, " tx_over(table)"}, 32'(tx_over), 32'(x.ov));
      check({tag, " rx_under(table)"}, 32'(rx_under), 32'(x.un));
   endtask

   initial begin
      model_reset();
      reset_n = 1'b0;
      drive_idle();
      repeat (3) @(negedge clk);

      check("reset tx_level", 32'(tx_level), 0);
      check("reset rx_level", 32'(rx_level), 0);
      check("reset tx_empty", 32'(tx_empty), 1);
      check("reset rx_empty", 32'(rx_empty), 1);
      check("reset tx_full", 32'(tx_full), 0);
      check("reset rx_full", 32'(rx_full), 0);
      check("reset tx_over", 32'(tx_over), 0);
      check("reset rx_under", 32'(rx_under), 0);
      reset_n = 1'b1;

      // jn fl clr tp td tpl rp rd rpl | txl rxl ov un
      // TX fill past full, then drain
      vecs.push_back(v(0,0,0,1,'hA0,0,0,0,0, 1,0,0,0));
      vecs.push_back(v(0,0,0,1,'hA1,0,0,0,0, 2,0,0,0));
      vecs.push_back(v(0,0,0,1,'hA2,0,0,0,0, 3,0,0,0));
      vecs.push_back(v(0,0,0,1,'hA3,0,0,0,0, 4,0,0,0));
      vecs.push_back(v(0,0,0,1,'hA4,0,0,0,0, 4,0,1,0));
      for (int i = 0; i < 4; i++) vecs.push_back(v(0,0,0,0,0,1,0,0,0, 3-i,0,1,0));
      vecs.push_back(v(0,0,1,0,0,0,0,0,0, 0,0,0,0));
      // Push+pull while full drops the push; push+pull while empty keeps it
      for (int i = 0; i < 4; i++) vecs.push_back(v(0,0,0,1,'hB0+i,0,0,0,0, i+1,0,0,0));
      vecs.push_back(v(0,0,0,1,'hBB,1,0,0,0, 3,0,1,0));
      for (int i = 0; i < 3; i++) vecs.push_back(v(0,0,0,0,0,1,0,0,0, 2-i,0,1,0));
      vecs.push_back(v(0,0,0,1,'hCC,1,0,0,0, 1,0,1,0));
      vecs.push_back(v(0,0,0,0,0,1,0,0,0, 0,0,1,0));
      vecs.push_back(v(0,0,1,0,0,0,0,0,0, 0,0,0,0));
      // RX underflow: sticky, set beats clear, clear alone clears
      vecs.push_back(v(0,0,0,0,0,0,0,0,1, 0,0,0,1));
      vecs.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,1));
      vecs.push_back(v(0,0,1,0,0,0,0,0,1, 0,0,0,1));
      vecs.push_back(v(0,0,1,0,0,0,0,0,0, 0,0,0,0));
      // Both directions concurrently, disjoint storage
      vecs.push_back(v(0,0,0,1,'hF0,0,1,'h31,0, 1,1,0,0));
      vecs.push_back(v(0,0,0,1,'hF1,0,1,'h32,0, 2,2,0,0));
      vecs.push_back(v(0,0,0,0,0,1,1,'h33,1, 1,2,0,0));
      vecs.push_back(v(0,0,0,0,0,1,0,0,1, 0,1,0,0));
      vecs.push_back(v(0,0,0,0,0,0,0,0,1, 0,0,0,0));
      // Flush beats a same-cycle push
      vecs.push_back(v(0,0,0,1,'hE0,0,0,0,0, 1,0,0,0));
      vecs.push_back(v(0,0,0,1,'hE1,0,0,0,0, 2,0,0,0));
      vecs.push_back(v(0,1,0,1,'hE2,0,0,0,0, 0,0,0,0));
      vecs.push_back(v(0,0,0,1,'hE3,0,0,0,0, 1,0,0,0));
      vecs.push_back(v(0,0,0,0,0,1,0,0,0, 0,0,0,0));
      // Join TX: change cycle discards push, 8 deep, RX disabled
      vecs.push_back(v(1,0,0,1,'h11,0,0,0,0, 0,0,0,0));
      for (int i = 0; i < 8; i++) vecs.push_back(v(1,0,0,1,'hD0+i,0,(i==3)?1:0,'h55,0, i+1,0,0,0));
      vecs.push_back(v(1,0,0,1,'hD8,0,0,0,0, 8,0,1,0));
      vecs.push_back(v(1,0,1,0,0,0,0,0,0, 8,0,0,0));
      for (int i = 0; i < 8; i++) vecs.push_back(v(1,0,0,0,0,1,0,0,0, 7-i,0,0,0));
      vecs.push_back(v(1,0,0,1,'hD9,0,0,0,0, 1,0,0,0));
      vecs.push_back(v(1,0,0,1,'hDA,0,0,0,0, 2,0,0,0));
      vecs.push_back(v(1,0,0,0,0,1,0,0,0, 1,0,0,0));
      vecs.push_back(v(1,0,0,0,0,1,0,0,0, 0,0,0,0));
      vecs.push_back(v(1,0,0,0,0,0,0,0,1, 0,0,0,1));
      vecs.push_back(v(1,0,1,0,0,0,0,0,0, 0,0,0,0));
      // Join RX: RX holding 3, change with push active discards all
      vecs.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0));
      for (int i = 0; i < 3; i++) vecs.push_back(v(0,0,0,0,0,0,1,'h41+i,0, 0,i+1,0,0));
      vecs.push_back(v(2,0,0,0,0,0,1,'h44,0, 0,0,0,0));
      for (int i = 0; i < 8; i++) vecs.push_back(v(2,0,0,0,0,0,1,'h50+i,0, 0,i+1,0,0));
      vecs.push_back(v(2,0,0,1,'h99,0,1,'h58,0, 0,8,1,0));
      vecs.push_back(v(2,0,1,0,0,0,0,0,0, 0,8,0,0));
      for (int i = 0; i < 8; i++) vecs.push_back(v(2,0,0,0,0,0,0,0,1, 0,7-i,0,0));
      // join=11 behaves as unjoined
      vecs.push_back(v(3,0,0,0,0,0,0,0,0, 0,0,0,0));
      vecs.push_back(v(3,0,0,1,'h61,0,0,0,0, 1,0,0,0));
      vecs.push_back(v(3,0,0,0,0,0,1,'h62,0, 1,1,0,0));
      vecs.push_back(v(3,1,0,0,0,0,0,0,0, 0,0,0,0));

      @(negedge clk);
      foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

      // Asynchronous reset mid-burst
      apply(v(3,0,0,1,'h70,0,1,'h80,0, 1,1,0,0), "burst0");
      apply(v(3,0,0,1,'h71,0,1,'h81,0, 2,2,0,0), "burst1");
      drive_idle();
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst tx_level", 32'(tx_level), 0);
      check("async_rst rx_level", 32'(rx_level), 0);
      check("async_rst tx_empty", 32'(tx_empty), 1);
      check("async_rst rx_empty", 32'(rx_empty), 1);
      model_reset();
      drive_idle();
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      apply(v(0,0,0,1,'h77,0,0,0,0, 1,0,0,0), "post_rst push");
      check("post_rst tx_dout", tx_dout, 32'h77);
      apply(v(0,0,0,0,0,1,0,0,0, 0,0,0,0), "post_rst pull");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pio_fifo_pair.md
# pio_fifo_pair

Parametrised TX/RX FIFO pair for one PIO state machine: TX carries words from the system bus to the state machine, RX carries words back. Both directions provide first-word-fall-through reads, level reporting and sticky overflow/underflow flags. A join mode donates one direction's storage to the other, giving a single FIFO of twice the depth. The block sits between the bus register interface and the state machine's PULL/PUSH logic.

## Interface
- WIDTH, 32: data word width in bits.
- DEPTH, 4: entries per direction when unjoined; power of two, ≥2. Joined depth is 2*DEPTH.
- LW (derived, not overridable): $clog2(2*DEPTH)+1, the width of the level outputs.
- clk  in  1  sole clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- join  in  2  00 none; 01 join TX; 10 join RX; 11 treated as 00.
- flush  in  1  synchronous clear of both FIFOs' contents.
- clr_flags  in  1  clears the sticky flags.
- tx_push  in  1  bus writes tx_din into TX.
- tx_din  in  WIDTH  TX write data.
- tx_pull  in  1  state machine consumes the TX head.
- tx_dout  out  WIDTH  TX head word.
- tx_empty, tx_full  out  1 each  TX status.
- tx_level  out  LW  TX occupancy.
- rx_push  in  1  state machine writes rx_din into RX.
- rx_din  in  WIDTH  RX write data.
- rx_pull  in  1  bus consumes the RX head.
- rx_dout  out  WIDTH  RX head word.
- rx_empty, rx_full  out  1 each  RX status.
- rx_level  out  LW  RX occupancy.
- tx_over  out  1  sticky: TX push attempted while tx_full.
- rx_under  out  1  sticky: RX pull attempted while rx_empty.

## Operation
- Storage is a single 2*DEPTH-entry array. Unjoined: TX uses entries 0..DEPTH-1 and RX uses DEPTH..2*DEPTH-1. Joined: the enabled direction uses all entries.
- Capacity: unjoined, each direction is DEPTH. join=01: TX 2*DEPTH, RX 0. join=10: RX 2*DEPTH, TX 0.
- A disabled (zero-capacity) direction reports empty=1, full=1, level=0. Its pushes and pulls are ignored but still set the flags.
- Accepted push = push && !full. Accepted pull = pull && !empty. These are evaluated independently per direction.
- Push while full is dropped even if a pull is accepted in the same cycle. The pull proceeds and the level decrements.
- Push and pull while empty: the push is accepted, the pull is ignored, and the level becomes 1.
- Push and pull both accepted: the level is unchanged and both pointers advance.
- Pointers wrap modulo the current capacity. Level ranges 0..capacity; full = (level == capacity), empty = (level == 0).
- dout is the array entry at the head pointer. It is valid only when !empty; its value when empty is unspecified.
- Join change: join is registered internally as join_q. In a cycle where join != join_q:
  - join_q is loaded;
  - both FIFOs flush (pointers and levels go to 0);
  - all pushes and pulls in that cycle are discarded.
- flush=1 has the same effect as a join change without altering join_q. Flush has priority over push and pull in the same cycle.
- tx_over sets on tx_push && tx_full. rx_under sets on rx_pull && rx_empty.
- clr_flags clears both flags. If a set and a clear occur in the same cycle, the set wins. Flush and join change do not affect the flags.

## Timing
- Asynchronous reset: levels 0, tx_empty=rx_empty=1, tx_full=rx_full=0, flags 0, join_q=00. Array contents are not reset.
- Push at edge N: the word is visible on dout and the level updates after edge N (readable in cycle N+1).
- Pull at edge N: the next head appears after edge N.
- Status outputs are decoded from registered state. There is no combinational path from push/pull to any output.
- join_q takes effect one cycle after join changes. In the change cycle, outputs still reflect the old mode.
- Reset asserted mid-transfer discards contents immediately. Operation resumes on the first edge after reset_n rises.

## Test plan
- DEPTH=4, join=00: push 0xA0..0xA4 into TX -> first 4 accepted, tx_full=1, tx_level=4, tx_over=1; pulls return 0xA0..0xA3 in order, then tx_empty=1.
- join=01: push 8 words -> tx_level=8, tx_full=1; rx_empty=rx_full=1; rx_push of 0x55 is ignored and rx_level stays 0; pulls return the 8 words in order, exercising wrap over entries 0..7.
- TX full, push 0xBB with pull together -> head popped, 0xBB dropped, tx_level=3, tx_over=1. TX empty, push 0xCC with pull together -> tx_level=1, tx_dout=0xCC.
- RX empty, rx_pull -> rx_under=1 and it stays set; clr_flags together with another rx_pull -> rx_under stays 1; clr_flags alone -> rx_under=0.
- RX holding 3 words, join changes 00->10 with rx_push active in the same cycle -> next cycle rx_level=0 and the push is discarded; then 8 pushes -> rx_full=1.
- reset_n pulsed low mid-burst, asynchronously between edges -> all levels 0 and empties 1 immediately; the next push after release is read back correctly.
